keypad_display_driver: RTL

Downstream stage of the keypad scanner: consumes the scanner's one-cycle key strobe and 4-bit key code, keeps a two-entry key history (newest on the right digit, previous on the left), and time-multiplexes both values onto a pair of common-anode seven-segment digits. A dead-time blanking interval between digit switches suppresses ghosting. Runs in the 48 MHz HSOSC domain and drives the board's `seg`/`control` pins directly.

---
 rtl/display_pkg.sv | 22 ++
 rtl/hex_to_seg.sv | 31 +++
 rtl/keypad_display_driver.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// Shared types and constants for the keypad display driver.
// The optional leading-blank behaviour is selected with LEADING_BLANK_EN.
package display_pkg;

  typedef enum logic [1:0] {
    SHOW_R   = 2'd0,
    BLANK_RL = 2'd1,
    SHOW_L   = 2'd2,
    BLANK_LR = 2'd3
  } refresh_state_t;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [1:0] CTRL_OFF  = 2'b11;

  localparam int DEF_REFRESH_CYCLES = 24000;
  localparam int DEF_BLANK_CYCLES   = 480;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hex_to_seg.sv
// Combinational hex-digit to active-low seven-segment decoder, bit order {g,f,e,d,c,b,a}.
// Letters b and d use the lowercase glyphs so they stay distinct from 8 and 0.
module hex_to_seg (
  input  logic [3:0] i_hex,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = 7'h7F;
    case (i_hex)
      4'h0: o_seg = 7'b1000000;
      4'h1: o_seg = 7'b1111001;
      4'h2: o_seg = 7'b0100100;
      4'h3: o_seg = 7'b0110000;
      4'h4: o_seg = 7'b0011001;
      4'h5: o_seg = 7'b0010010;
      4'h6: o_seg = 7'b0000010;
      4'h7: o_seg = 7'b1111000;
      4'h8: o_seg = 7'b0000000;
      4'h9: o_seg = 7'b0010000;
      4'hA: o_seg = 7'b0001000;
      4'hB: o_seg = 7'b0000011;
      4'hC: o_seg = 7'b1000110;
      4'hD: o_seg = 7'b0100001;
      4'hE: o_seg = 7'b0000110;
      4'hF: o_seg = 7'b0001110;
      default: o_seg = 7'h7F;
    endcase
  end

endmodule

// File: rtl/keypad_display_driver.sv
// Two-entry key history multiplexed onto two common-anode digits with dead-time blanking.
// Define LEADING_BLANK_EN to darken digits that have not yet received a key.
module keypad_display_driver
  import display_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int BLANK_CYCLES   = DEF_BLANK_CYCLES
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       key_valid,
  input  logic [3:0] key_code,
  output logic [1:0] control,
  output logic [6:0] seg
);

  localparam int CNT_W = $clog2(max_int(REFRESH_CYCLES, BLANK_CYCLES));
  localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);

  refresh_state_t   r_state;
  refresh_state_t   w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic             r_started;
  logic             w_cnt_last;
  logic [3:0]       r_hex_r;
  logic [3:0]       r_hex_l;
  logic [3:0]       w_hex_sel;
  logic [6:0]       w_seg_dec;
  logic [1:0]       r_control;
  logic [6:0]       r_seg;
  logic [1:0]       w_control_nxt;
  logic [6:0]       w_seg_nxt;
`ifdef LEADING_BLANK_EN
  logic             r_vld_r;
  logic             r_vld_l;
`endif

  // The first edge after reset release only arms the scheduler, so the
  // first enabled digit appears on the second edge with a full slot.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_started <= 1'b0;
    else          r_started <= 1'b1;
  end

  always_comb begin
    w_cnt_last  = 1'b0;
    w_state_nxt = r_state;
    case (r_state)
      SHOW_R: begin
        w_cnt_last = (r_cnt == SHOW_LAST);
        if (w_cnt_last) w_state_nxt = BLANK_RL;
      end
      BLANK_RL: begin
        w_cnt_last = (r_cnt == BLANK_LAST);
        if (w_cnt_last) w_state_nxt = SHOW_L;
      end
      SHOW_L: begin
        w_cnt_last = (r_cnt == SHOW_LAST);
        if (w_cnt_last) w_state_nxt = BLANK_LR;
      end
      BLANK_LR: begin
        w_cnt_last = (r_cnt == BLANK_LAST);
        if (w_cnt_last) w_state_nxt = SHOW_R;
      end
      default: w_state_nxt = SHOW_R;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= SHOW_R;
      r_cnt   <= '0;
    end else if (r_started) begin
      r_state <= w_state_nxt;
      if (w_state_nxt != r_state) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hex_r <= 4'h0;
      r_hex_l <= 4'h0;
`ifdef LEADING_BLANK_EN
      r_vld_r <= 1'b0;
      r_vld_l <= 1'b0;
`endif
    end else if (key_valid) begin
      r_hex_l <= r_hex_r;
      r_hex_r <= key_code;
`ifdef LEADING_BLANK_EN
      r_vld_l <= r_vld_r;
      r_vld_r <= 1'b1;
`endif
    end
  end

  assign w_hex_sel = (r_state == SHOW_L) ? r_hex_l : r_hex_r;

  hex_to_seg u_hex_to_seg (
    .i_hex (w_hex_sel),
    .o_seg (w_seg_dec)
  );

  always_comb begin
    w_control_nxt = CTRL_OFF;
    w_seg_nxt     = SEG_BLANK;
    if (r_started) begin
      case (r_state)
        SHOW_R: begin
          w_control_nxt = 2'b10;
          w_seg_nxt     = w_seg_dec;
`ifdef LEADING_BLANK_EN
          if (!r_vld_r) w_seg_nxt = SEG_BLANK;
`endif
        end
        SHOW_L: begin
          w_control_nxt = 2'b01;
          w_seg_nxt     = w_seg_dec;
`ifdef LEADING_BLANK_EN
          if (!r_vld_l) w_seg_nxt = SEG_BLANK;
`endif
        end
        default: begin
          w_control_nxt = CTRL_OFF;
          w_seg_nxt     = SEG_BLANK;
        end
      endcase
    end
  end

  // Enable and pattern are registered together so a digit is never lit
  // with the other digit's segments.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_control <= CTRL_OFF;
      r_seg     <= SEG_BLANK;
    end else begin
      r_control <= w_control_nxt;
      r_seg     <= w_seg_nxt;
    end
  end

  assign control = r_control;
  assign seg     = r_seg;

endmodule
